// File: rtl/shiftreg_right_alu_if.sv
// shiftreg_right_alu_if: ALU bus (op/en/operands in, result/status out) for the right-shift unit.
interface shiftreg_right_alu_if #(
   parameter int WIDTH_IN = 3,
   parameter int CNT_W    = 3
);
   logic                  en;
   logic [1:0]            op;
   logic [WIDTH_IN-1:0]   A;
   logic [WIDTH_IN-1:0]   B;
   logic [CNT_W-1:0]      amount;
   logic                  arith;
   logic [2*WIDTH_IN-1:0] Doutshift;
   logic                  busy;
   logic                  done;
   modport master (output en, op, A, B, amount, arith, input Doutshift, busy, done);
   modport slave  (input en, op, A, B, amount, arith, output Doutshift, busy, done);
endinterface

// File: rtl/shiftreg_right_alu.sv
// shiftreg_right_alu: loads {A,B} and shifts it right one bit per enabled clock, logical or arithmetic.
module shiftreg_right_alu #(
   parameter int         WIDTH_IN = 3,
   parameter logic [1:0] OP_CODE  = 2'b10,
   parameter int         CNT_W    = 3
) (
   input logic clk,
   input logic rst,
   shiftreg_right_alu_if.slave bus
);
   localparam int W = 2 * WIDTH_IN;
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t           state_q, state_d;
   logic [W-1:0]     dout_q, dout_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             arith_q, arith_d, busy_q, busy_d, done_q, done_d;
   logic [W-1:0]     ld;
   function automatic logic [W-1:0] shr(input logic [W-1:0] x, input logic a);
      return {a & x[W-1], x[W-1:1]};
   endfunction
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         dout_q  <= '0;
         cnt_q   <= '0;
         arith_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dout_q  <= dout_d;
         cnt_q   <= cnt_d;
         arith_q <= arith_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end
   // Amounts 0 and 1 finish in the start cycle; only N>=2 enters SHIFT.
   always_comb begin
      state_d = state_q;
      dout_d  = dout_q;
      cnt_d   = cnt_q;
      arith_d = arith_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      ld      = {bus.A, bus.B};
      if (bus.en) begin
         if (state_q == SHIFT) begin
            dout_d = shr(dout_q, arith_q);
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end else if (bus.op == OP_CODE) begin
            dout_d = (bus.amount == '0) ? ld : shr(ld, bus.arith);
            done_d = bus.amount < CNT_W'(2);
            if (bus.amount >= CNT_W'(2)) begin
               cnt_d   = bus.amount - CNT_W'(1);
               arith_d = bus.arith;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
      end
   end
   assign bus.Doutshift = dout_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
endmodule

// File: doc/shiftreg_right_alu.md
Name: shiftreg_right_ALU

Overview:
- Right-shift function unit of the 3-bit ALU; the opposite direction of the existing left-shift unit.
- On a start request it concatenates {A,B} into a 6-bit register and shifts it right by a programmable amount, one bit per enabled clock.
- Logical or arithmetic fill.
- Sits beside the left-shift unit on the same op/en/A/B bus and drives its own 6-bit result plus busy/done status to the ALU output mux.

Parameters:
- WIDTH_IN, 3, width of each operand A and B; the result is 2*WIDTH_IN bits.
- OP_CODE, 2'b10, op value that selects this unit.
- CNT_W, 3, width of the amount input; maximum shift is 2^CNT_W-1.

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  ALU enable; when low, all state holds.
- op  input  2  ALU function select; start requires op==OP_CODE.
- A  input  WIDTH_IN  upper operand; becomes Doutshift[5:3].
- B  input  WIDTH_IN  lower operand; becomes Doutshift[2:0].
- amount  input  CNT_W  number of right shifts requested; sampled at start only.
- arith  input  1  1 = replicate MSB into the vacated bit, 0 = fill with 0; sampled at start only.
- Doutshift  output  2*WIDTH_IN  shift register contents, registered.
- busy  output  1  high while a multi-cycle shift is in progress.
- done  output  1  one-cycle pulse; high in the cycle the final result is valid on Doutshift.

Behaviour:
- Reset: rst=1 forces the following immediately, independent of clk, and held while rst=1:
  - Doutshift=0, busy=0, done=0.
  - Remaining-count register=0, latched arith=0, state=IDLE.
- Definitions:
  - start = en & (op==OP_CODE) & state==IDLE.
  - shr(x) = {fill, x[5:1]}, where fill = x[5] if the latched arith=1, else 0.
- en=0, any state: no register changes (Doutshift, count, state, busy hold); done is forced 0 on the next edge.
- Timing: done is registered, so it and the final Doutshift value appear after the same edge.
- State IDLE:
  - start with amount==0: Doutshift<={A,B}; done<=1; stay IDLE.
  - start with amount==1: Doutshift<=shr({A,B}); done<=1; stay IDLE.
  - start with amount>=2: Doutshift<=shr({A,B}); count<=amount-1; latch arith; busy<=1; state<=SHIFT.
  - No start: Doutshift holds; done<=0.
- State SHIFT, en=1:
  - Doutshift<=shr(Doutshift); count<=count-1.
  - If count==1: busy<=0, done<=1, state<=IDLE.
  - op, A, B, amount and arith are ignored in SHIFT; a change of op mid-shift does not abort.
- Latency: start at edge k with amount N>=1 gives the final value and done after edge k+N-1 (plus any en-low cycles). busy is high from edge k to edge k+N-1 when N>=2.
- Back-to-back: a start in the cycle where done=1 is legal. The new operands load, and done follows the new operation's rules.
- Saturation: arith with N>=5 saturates to all copies of the MSB; logical with N>=6 gives 0.
- Reset mid-operation: abandons the shift with no done pulse. The unit is ready for start on the first enabled edge after rst falls.
- Idle result: Doutshift retains the last result indefinitely while idle.

Test Plan:
1. Reset: rst pulsed high mid-cycle during SHIFT (Doutshift=010110) -> Doutshift=000000, busy=0, done=0 before the next clk edge; state IDLE after rst falls.
2. Logical shift: A=101, B=100, amount=3, arith=0, op=10, en=1 -> Doutshift 010110, 001011, 000101 on successive edges; busy high for edges 1-2; done=1 with 000101 after edge 3 only.
3. Arithmetic shift: same operands, amount=2, arith=1 -> 110110, then 111011 with done; arith=1, A=100, B=000, amount=7 -> 111111 after edge 7.
4. Enable gating: the test 2 stimulus with en=0 for 2 cycles after the first shift -> Doutshift holds 010110; done is delayed to edge 5 with the value 000101.
5. Zero/one amount and back-to-back:
   - amount=0 -> Doutshift=101100, done 1 cycle, busy never high.
   - A new start (amount=1, A=011, B=000) issued in the done cycle -> 001100 with done on the next edge.
6. Wrong op / mid-shift op change:
   - op=01 with en=1 in IDLE -> no change to Doutshift, done=0.
   - op switched to 01 during SHIFT -> shift completes normally with done.
